// File: rtl/gate_vector_checker.sv
// Exhaustive 2-input gate checker: steps {a,b} through all four vectors,
// compares the seven gate outputs against a golden table, keeps sticky stats.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERRCNT_W      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [6:0]          y,
    output logic                a,
    output logic                b,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [6:0]          fail_mask,
    output logic [3:0]          fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SUM_W = ERRCNT_W + 3;
    localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FIN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [6:0]          golden;
    logic [6:0]          mism;
    logic [2:0]          mism_pop;
    logic [SUM_W-1:0]    err_sum;
    logic [ERRCNT_W-1:0] err_next;
    logic [3:0]          vec_hit;

    // Bit order matches y: and, or, not(a), nand, nor, xor, xnor
    function automatic logic [6:0] gold_of(input logic ga, input logic gb);
        return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb),
                ~ga, ga | gb, ga & gb};
    endfunction

    always_comb begin
        golden   = gold_of(a, b);
        mism     = y ^ golden;
        mism_pop = 3'($countones(mism));
        err_sum  = SUM_W'(err_count) + SUM_W'(mism_pop);
        err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX
                                               : err_sum[ERRCNT_W-1:0];
        vec_hit  = 4'b0000;
        vec_hit[{a, b}] = |mism;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
            fail_vec  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a         <= 1'b0;
                        b         <= 1'b0;
                        cnt       <= '0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_mask <= '0;
                        fail_vec  <= '0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    fail_mask <= fail_mask | mism;
                    fail_vec  <= fail_vec | vec_hit;
                    err_count <= err_next;
                    if (a && b) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= FIN;
                    end else begin
                        {a, b} <= {a, b} + 2'b01;
                        cnt    <= '0;
                        state  <= SETTLE;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: behavioural gate models with
// injected faults feed two checker instances; results go through a scoreboard.
module tb_gate_vector_checker;

    typedef enum int {M_GOLD, M_XOR0, M_NOTB, M_INV, M_LAT} mode_t;

    typedef struct {
        string      tag;
        logic       pass;
        logic [4:0] err;
        logic [6:0] mask;
        logic [3:0] vec;
        bit         full;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    mode_t mode1 = M_GOLD;
    mode_t mode2 = M_GOLD;

    logic [6:0] y1, y2;
    logic a1, b1, busy1, done1, pass1;
    logic a2, b2, busy2, done2, pass2;
    logic [4:0] err1;
    logic [3:0] err2;
    logic [6:0] mask1, mask2;
    logic [3:0] vec1, vec2;
    logic [6:0] y1_d1, y1_d2, y2_d1, y2_d2;

    int sel = 0;
    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    logic o_a, o_b, o_busy, o_done, o_pass;
    logic [4:0] o_err;
    logic [6:0] o_mask;
    logic [3:0] o_vec;

    always #5 clk = ~clk;

    gate_vector_checker #(.SETTLE_CYCLES(2), .ERRCNT_W(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1), .fail_vec(vec1)
    );

    gate_vector_checker #(.SETTLE_CYCLES(1), .ERRCNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(mask2), .fail_vec(vec2)
    );

    function automatic logic [6:0] gold(input logic ga, input logic gb);
        logic [6:0] g;
        g[0] = ga & gb;
        g[1] = ga | gb;
        g[2] = ~ga;
        g[3] = ~(ga & gb);
        g[4] = ~(ga | gb);
        g[5] = ga ^ gb;
        g[6] = ~(ga ^ gb);
        return g;
    endfunction

    function automatic logic [6:0] model(input mode_t m, input logic ma,
                                         input logic mb);
        logic [6:0] g;
        g = gold(ma, mb);
        case (m)
            M_XOR0:  g[5] = 1'b0;
            M_NOTB:  g[2] = ~mb;
            M_INV:   g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    // Two-stage registered model for the latency cases
    always @(posedge clk) begin
        y1_d1 <= gold(a1, b1);
        y1_d2 <= y1_d1;
        y2_d1 <= gold(a2, b2);
        y2_d2 <= y2_d1;
    end

    always_comb begin
        y1 = (mode1 == M_LAT) ? y1_d2 : model(mode1, a1, b1);
        y2 = (mode2 == M_LAT) ? y2_d2 : model(mode2, a2, b2);
    end

    always_comb begin
        if (sel == 0) begin
            {o_a, o_b, o_busy, o_done, o_pass} = {a1, b1, busy1, done1, pass1};
            o_err  = err1;
            o_mask = mask1;
            o_vec  = vec1;
        end else begin
            {o_a, o_b, o_busy, o_done, o_pass} = {a2, b2, busy2, done2, pass2};
            o_err  = {1'b0, err2};
            o_mask = mask2;
            o_vec  = vec2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".a"}, 32'(o_a), 0);
        chk({tag, ".b"}, 32'(o_b), 0);
        chk({tag, ".busy"}, 32'(o_busy), 0);
        chk({tag, ".done"}, 32'(o_done), 0);
        chk({tag, ".pass"}, 32'(o_pass), 0);
        chk({tag, ".err"}, 32'(o_err), 0);
        chk({tag, ".mask"}, 32'(o_mask), 0);
        chk({tag, ".vec"}, 32'(o_vec), 0);
    endtask

    task automatic push(input string tag, input logic p, input logic [4:0] e,
                        input logic [6:0] m, input logic [3:0] v,
                        input bit full);
        exp_t x;
        x.tag = tag;
        x.pass = p;
        x.err = e;
        x.mask = m;
        x.vec = v;
        x.full = full;
        sb.push_back(x);
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start1 = v;
        else start2 = v;
    endtask

    task automatic start_run(input bit hold);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        if (!hold) set_start(1'b0);
    endtask

    // Waits for done; exp_done is the done cycle index after the start edge
    task automatic wait_done(input int exp_done, input bit mid_pulse);
        exp_t x;
        int k = 1;
        int nbusy = 0;
        while (!o_done && k < 200) begin
            if (o_busy) nbusy++;
            @(negedge clk);
            k++;
            if (mid_pulse && k == 5) set_start(1'b1);
            if (mid_pulse && k == 6) set_start(1'b0);
        end
        if (!o_done) begin
            n_cmp++;
            n_err++;
            $error("FAIL timeout: done not seen after %0d cycles", k);
        end
        if (exp_done > 0) begin
            chk("done_cycle", 32'(k), 32'(exp_done));
            chk("busy_cycles", 32'(nbusy), 32'(exp_done - 1));
        end
        chk("busy_in_fin", 32'(o_busy), 0);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard: empty at done");
        end else begin
            x = sb.pop_front();
            chk({x.tag, ".pass"}, 32'(o_pass), 32'(x.pass));
            if (x.full) begin
                chk({x.tag, ".err"}, 32'(o_err), 32'(x.err));
                chk({x.tag, ".mask"}, 32'(o_mask), 32'(x.mask));
                chk({x.tag, ".vec"}, 32'(o_vec), 32'(x.vec));
            end else begin
                chk({x.tag, ".vec_nz"}, 32'(o_vec != 4'd0), 1);
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 0);
        chk("idle_busy", 32'(o_busy), 0);
    endtask

    initial begin
        int k;
        #12;
        sel = 0;
        chk_zero_outputs("rst1");
        sel = 1;
        chk_zero_outputs("rst2");
        @(negedge clk);
        rst_n = 1'b1;

        sel = 0;
        mode1 = M_GOLD;
        push("gold", 1, 0, 7'b0000000, 4'b0000, 1);
        start_run(0);
        chk("vec00_a", 32'({o_a, o_b}), 0);
        wait_done(13, 0);

        mode1 = M_XOR0;
        push("xor0", 0, 2, 7'b0100000, 4'b0110, 1);
        start_run(0);
        wait_done(13, 0);

        mode1 = M_NOTB;
        push("notb", 0, 2, 7'b0000100, 4'b0110, 1);
        start_run(0);
        wait_done(13, 0);

        mode1 = M_INV;
        push("inv5", 0, 28, 7'b1111111, 4'b1111, 1);
        start_run(0);
        wait_done(13, 0);

        mode1 = M_LAT;
        push("lat_s2", 1, 0, 7'b0000000, 4'b0000, 1);
        start_run(0);
        wait_done(13, 0);

        mode1 = M_GOLD;
        push("midstart", 1, 0, 7'b0000000, 4'b0000, 1);
        start_run(0);
        wait_done(13, 1);

        push("hold1", 1, 0, 7'b0000000, 4'b0000, 1);
        push("hold2", 1, 0, 7'b0000000, 4'b0000, 1);
        start_run(1);
        wait_done(13, 0);
        @(negedge clk);
        chk("hold_restart", 32'(o_busy), 1);
        start1 = 1'b0;
        wait_done(0, 0);

        sel = 1;
        mode2 = M_INV;
        push("inv4_sat", 0, 15, 7'b1111111, 4'b1111, 1);
        start_run(0);
        wait_done(9, 0);

        mode2 = M_LAT;
        push("lat_s1", 0, 0, 7'b0000000, 4'b0000, 0);
        start_run(0);
        wait_done(9, 0);

        mode2 = M_GOLD;
        push("gold_s1", 1, 0, 7'b0000000, 4'b0000, 1);
        start_run(0);
        wait_done(9, 0);

        sel = 0;
        mode1 = M_XOR0;
        start_run(0);
        k = 0;
        while (!(o_a && !o_b) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reach_vec10", 32'({o_a, o_b}), 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(o_done), 0);
        end
        rst_n = 1'b1;
        mode1 = M_GOLD;
        push("after_rst", 1, 0, 7'b0000000, 4'b0000, 1);
        start_run(0);
        wait_done(13, 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
